// File: rtl/muldiv_pkg.sv
// Shared op codes, op-field bit positions and FSM state type for the sequential mul/div unit.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT_S = 4'b0000;
    localparam logic [3:0] OP_DIV_S  = 4'b0001;
    localparam logic [3:0] OP_MULT_U = 4'b1000;
    localparam logic [3:0] OP_DIV_U  = 4'b1001;

    localparam int unsigned OP_DIV_BIT = 0;
    localparam int unsigned OP_UNS_BIT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StIter,
        StFix
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_MULT_S, OP_DIV_S, OP_MULT_U, OP_DIV_U};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Combinational single-step datapath: one radix-2 shift-add (multiply) or one restoring
// division step, on an accumulator laid out as {upper half, lower half}.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opd,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        upper   = acc[2*WIDTH-1:WIDTH];
        lower   = acc[WIDTH-1:0];
        // Multiply: upper = partial product, lower = remaining multiplier bits.
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, opd} : '0);
        // Divide: upper = partial remainder, lower = dividend bits / quotient bits.
        shifted = {upper, lower[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opd;
        if (is_div) begin
            if (shifted >= {1'b0, opd}) begin
                acc_nxt = {diff, lower[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {shifted[WIDTH-1:0], lower[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {sum, lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/DIV unit with HI/LO registers, one bit per cycle, start/busy/done handshake.
// Optional MULDIV_DIVZERO_EN: early divide-by-zero termination with a div0 flag.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             div0
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               uns_q, uns_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
    logic               div0_q, div0_d;
`endif

    logic [2*WIDTH-1:0] iter_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix, hi_mt, lo_mt;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .is_div (is_div_q),
        .acc    (acc_q),
        .opd    (opd_q),
        .acc_nxt(iter_acc)
    );

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        uns_d     = uns_q;
        a_d       = a_q;
        b_d       = b_q;
        opd_d     = opd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        div0_d    = 1'b0;
`endif
        hi_mt     = mthi ? wdata : hi_q;
        lo_mt     = mtlo ? wdata : lo_q;
        hi_d      = hi_mt;
        lo_d      = lo_mt;

        abs_a   = (!uns_q && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b   = (!uns_q && b_q[WIDTH-1]) ? -b_q : b_q;
        prod    = neg_res_q ? -acc_q : acc_q;
        quo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            StIdle: begin
                if (start && op_legal(m) && !flush) begin
                    state_d  = StPrep;
                    a_d      = a;
                    b_d      = b;
                    is_div_d = m[OP_DIV_BIT];
                    uns_d    = m[OP_UNS_BIT];
                end
            end
            StPrep: begin
                neg_res_d = !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = !uns_q && is_div_q && a_q[WIDTH-1];
                cnt_d     = '0;
                // Divide iterates on the dividend with the divisor as operand;
                // multiply iterates on the multiplier with the multiplicand as operand.
                if (is_div_q) begin
                    opd_d = abs_b;
                    acc_d = {{WIDTH{1'b0}}, abs_a};
                end else begin
                    opd_d = abs_a;
                    acc_d = {{WIDTH{1'b0}}, abs_b};
                end
                state_d = StIter;
`ifdef MULDIV_DIVZERO_EN
                if (is_div_q && (b_q == '0)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    div0_d  = 1'b1;
                end
`endif
            end
            StIter: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort discards the op, including a completion due on this edge.
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_mt;
            lo_d    = lo_mt;
`ifdef MULDIV_DIVZERO_EN
            div0_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            is_div_q  <= 1'b0;
            uns_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            opd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            uns_q     <= uns_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opd_q     <= opd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_DIVZERO_EN
            div0_q    <= div0_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
`ifdef MULDIV_DIVZERO_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed handshake/corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, mthi, mtlo;
    logic [3:0]  m;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done;
`ifdef MULDIV_DIVZERO_EN
    logic        div0;
`endif

    int errors = 0;
    int checks = 0;

    muldiv_seq #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .m    (m),
        .a    (a),
        .b    (b),
        .flush(flush),
        .mthi (mthi),
        .mtlo (mtlo),
        .wdata(wdata),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
`ifdef MULDIV_DIVZERO_EN
        ,
        .div0 (div0)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            4'b0000: return sx * sy;
            4'b1000: return ux * uy;
            4'b1001: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {32'(x % y), 32'(x / y)};
            end
            default: begin
                // Divide by zero: quotient magnitude all ones, remainder magnitude |x|.
                if (y == 0) return {x, (sx < 0) ? 32'd1 : 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        m     = op;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since the start edge.
    task automatic wait_done(output int lat, output int bcnt);
        int cyc;
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc <= 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y);
        int lat, bcnt;
        logic [63:0] exp;
        exp = model(op, x, y);
        launch(op, x, y);
        wait_done(lat, bcnt);
        chk({tag, "_latency"}, 64'(lat), 64'd34);
        chk({tag, "_busycycles"}, 64'(bcnt), 64'd34);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [3:0]  ops [4];
        logic [3:0]  op;
        logic [31:0] x, y;
        logic [63:0] got;
        int          ndone, lat, bcnt;

        ops[0] = 4'b0000;
        ops[1] = 4'b0001;
        ops[2] = 4'b1000;
        ops[3] = 4'b1001;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        m     = 4'b0000;
        a     = '0;
        b     = '0;
        wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);

        // MTLO in IDLE
        mtlo  = 1'b1;
        wdata = 32'h55;
        @(negedge clk);
        mtlo  = 1'b0;
        chk("mtlo_idle", 64'(lo), 64'h55);

        run_op("smul_m1x1", 4'b0000, 32'hFFFF_FFFF, 32'd1);
        chk("smul_m1x1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("umul_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("umul_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("sdiv_m7_2", 4'b0001, 32'hFFFF_FFF9, 32'd2);
        chk("sdiv_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("sdiv_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("sdiv_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // Unsigned 100/7 with a second start while busy
        launch(4'b1001, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1;
        m     = 4'b0000;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        got   = '0;
        repeat (45) begin
            if (done) begin
                ndone++;
                got = {hi, lo};
            end
            @(negedge clk);
        end
        chk("udiv_100_7_ndone", 64'(ndone), 64'd1);
        chk("udiv_100_7_hilo", got, {32'd2, 32'd14});

        // Flush mid-divide keeps HI/LO
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h11;
        @(negedge clk);
        mthi  = 1'b0;
        wdata = 32'h22;
        @(negedge clk);
        mtlo  = 1'b0;
        launch(4'b1001, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});

        // Flush together with start cancels it
        start = 1'b1;
        flush = 1'b1;
        m     = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);

        // Illegal op is ignored
        launch(4'b0010, 32'd5, 32'd6);
        chk("illegal_busy", 64'(busy), 64'd0);
        ndone = 0;
        repeat (5) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("illegal_no_done", 64'(ndone), 64'd0);

        // MTHI during ITER, then overwritten by completion
        launch(4'b1000, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'hABCD;
        @(negedge clk);
        mthi  = 1'b0;
        chk("mthi_iter", 64'(hi), 64'hABCD);
        wait_done(lat, bcnt);
        chk("mthi_overwrite", {hi, lo}, 64'd42);

`ifdef MULDIV_DIVZERO_EN
        launch(4'b1001, 32'd9, 32'd0);
        chk("div0_early_busy", {62'd0, done, div0}, 64'd0);
        @(negedge clk);
        chk("div0_pulse", {62'd0, done, div0}, 64'd3);
        chk("div0_hilo_kept", {hi, lo}, 64'd42);
`else
        run_op("udiv_by0", 4'b1001, 32'd9, 32'd0);
        chk("udiv_by0_const", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        run_op("sdiv_by0", 4'b0001, 32'hFFFF_FFF7, 32'd0);
`endif

        // Random ops against the model
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 3)];
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 4 == 1) x = 32'($urandom_range(0, 300));
`ifdef MULDIV_DIVZERO_EN
            if (op[0] && y == 0) y = 32'd1;
`endif
            run_op($sformatf("rand%0d_op%0h", i, op), op, x, y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
